voice_sweeper: RTL and testbench



---
 rtl/voice_sweeper_pkg.sv | 17 +
 rtl/voice_sweeper_table.sv | 67 ++++++
 rtl/voice_sweeper.sv | 150 +++++++++++++++
 tb/tb_voice_sweeper.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/voice_sweeper_pkg.sv
// Shared synth definitions for the voice sweeper: bus widths, sweep FSM states
// and the phase-to-address slice width.
package voice_sweeper_pkg;

  localparam int unsigned WT_ADDR_W    = 10;
  localparam int unsigned SAMPLE_W     = 18;
  // Wavetable address is the top ADDR_SLICE_W bits of the phase accumulator.
  localparam int unsigned ADDR_SLICE_W = WT_ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ_R = 2'd1,
    REQ_L = 2'd2,
    NEXT  = 2'd3
  } state_t;

endpackage

// File: rtl/voice_sweeper_table.sv
// Per-voice parameter store: registered config write, async read by voice index,
// phase write-back; a gate rising edge on config write clears the phase.
module voice_table
  import voice_sweeper_pkg::*;
#(
  parameter int unsigned NVOICES = 16,
  parameter int unsigned PHASE_W = 26,
  localparam int unsigned VOICE_W = $clog2(NVOICES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [VOICE_W-1:0]  cfg_voice,
  input  logic                cfg_gate,
  input  logic [PHASE_W-1:0]  cfg_inc,
  input  logic [SAMPLE_W-1:0] cfg_gain_r,
  input  logic [SAMPLE_W-1:0] cfg_gain_l,
  input  logic [VOICE_W-1:0]  rd_voice,
  output logic                rd_gate,
  output logic [PHASE_W-1:0]  rd_inc,
  output logic [PHASE_W-1:0]  rd_phase,
  output logic [SAMPLE_W-1:0] rd_gain_r,
  output logic [SAMPLE_W-1:0] rd_gain_l,
  input  logic                wb_we,
  input  logic [VOICE_W-1:0]  wb_voice,
  input  logic [PHASE_W-1:0]  wb_phase
);

  logic                gate_q   [NVOICES];
  logic [PHASE_W-1:0]  inc_q    [NVOICES];
  logic [PHASE_W-1:0]  phase_q  [NVOICES];
  logic [SAMPLE_W-1:0] gain_r_q [NVOICES];
  logic [SAMPLE_W-1:0] gain_l_q [NVOICES];

  // Config write is ordered after write-back so a note-on clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NVOICES); i++) begin
        gate_q[i]   <= 1'b0;
        inc_q[i]    <= '0;
        phase_q[i]  <= '0;
        gain_r_q[i] <= '0;
        gain_l_q[i] <= '0;
      end
    end else begin
      if (wb_we) begin
        phase_q[wb_voice] <= wb_phase;
      end
      if (cfg_we) begin
        gate_q[cfg_voice]   <= cfg_gate;
        inc_q[cfg_voice]    <= cfg_inc;
        gain_r_q[cfg_voice] <= cfg_gain_r;
        gain_l_q[cfg_voice] <= cfg_gain_l;
        if (!gate_q[cfg_voice] && cfg_gate) begin
          phase_q[cfg_voice] <= '0;
        end
      end
    end
  end

  assign rd_gate   = gate_q[rd_voice];
  assign rd_inc    = inc_q[rd_voice];
  assign rd_phase  = phase_q[rd_voice];
  assign rd_gain_r = gain_r_q[rd_voice];
  assign rd_gain_l = gain_l_q[rd_voice];

endmodule

// File: rtl/voice_sweeper.sv
// Per-sample voice sweep: for each gated voice issue an R then an L wavetable
// request at the voice's phase, present the matching gain one cycle later.
module voice_sweeper
  import voice_sweeper_pkg::*;
#(
  parameter int unsigned NVOICES = 16,
  parameter int unsigned PHASE_W = 26,
  localparam int unsigned VOICE_W = $clog2(NVOICES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick48k,
  input  logic                 cfg_we,
  input  logic [VOICE_W-1:0]   cfg_voice,
  input  logic                 cfg_gate,
  input  logic [PHASE_W-1:0]   cfg_inc,
  input  logic [SAMPLE_W-1:0]  cfg_gain_r,
  input  logic [SAMPLE_W-1:0]  cfg_gain_l,
  output logic [WT_ADDR_W-1:0] wavetable_r,
  output logic                 wavetable_r_valid,
  output logic [WT_ADDR_W-1:0] wavetable_l,
  output logic                 wavetable_l_valid,
  output logic [SAMPLE_W-1:0]  volume,
  output logic                 busy,
  output logic                 overrun
);

  localparam logic [VOICE_W-1:0] LAST_V = VOICE_W'(NVOICES - 1);

  state_t               state_q, state_d;
  logic [VOICE_W-1:0]   v_q, v_d;
  logic [WT_ADDR_W-1:0] r_addr_d, l_addr_d;
  logic                 r_valid_d, l_valid_d, busy_d, overrun_d;
  logic [SAMPLE_W-1:0]  volume_d;
  logic                 wb_we;

  logic                 rd_gate;
  logic [PHASE_W-1:0]   rd_inc, rd_phase;
  logic [SAMPLE_W-1:0]  rd_gain_r, rd_gain_l;
  logic [WT_ADDR_W-1:0] cur_addr;

  assign cur_addr = rd_phase[PHASE_W-1 -: ADDR_SLICE_W];

  voice_table #(
    .NVOICES (NVOICES),
    .PHASE_W (PHASE_W)
  ) u_table (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_voice  (cfg_voice),
    .cfg_gate   (cfg_gate),
    .cfg_inc    (cfg_inc),
    .cfg_gain_r (cfg_gain_r),
    .cfg_gain_l (cfg_gain_l),
    .rd_voice   (v_q),
    .rd_gate    (rd_gate),
    .rd_inc     (rd_inc),
    .rd_phase   (rd_phase),
    .rd_gain_r  (rd_gain_r),
    .rd_gain_l  (rd_gain_l),
    .wb_we      (wb_we),
    .wb_voice   (v_q),
    .wb_phase   (rd_phase + rd_inc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= IDLE;
      v_q               <= '0;
      wavetable_r       <= '0;
      wavetable_r_valid <= 1'b0;
      wavetable_l       <= '0;
      wavetable_l_valid <= 1'b0;
      volume            <= '0;
      busy              <= 1'b0;
      overrun           <= 1'b0;
    end else begin
      state_q           <= state_d;
      v_q               <= v_d;
      wavetable_r       <= r_addr_d;
      wavetable_r_valid <= r_valid_d;
      wavetable_l       <= l_addr_d;
      wavetable_l_valid <= l_valid_d;
      volume            <= volume_d;
      busy              <= busy_d;
      overrun           <= overrun_d;
    end
  end

  // Requests are decoded from the next state so they appear in REQ_R/REQ_L.
  always_comb begin
    state_d   = state_q;
    v_d       = v_q;
    r_valid_d = 1'b0;
    l_valid_d = 1'b0;
    r_addr_d  = '0;
    l_addr_d  = '0;
    volume_d  = '0;
    overrun_d = overrun;
    wb_we     = 1'b0;

    case (state_q)
      IDLE: begin
        if (tick48k) begin
          state_d = NEXT;
          v_d     = '0;
        end
      end
      NEXT: begin
        if (rd_gate) begin
          state_d = REQ_R;
        end else begin
          v_d = v_q + VOICE_W'(1);
          if (v_q == LAST_V) state_d = IDLE;
        end
      end
      REQ_R: begin
        state_d  = REQ_L;
        volume_d = rd_gain_r;
      end
      REQ_L: begin
        wb_we    = 1'b1;
        volume_d = rd_gain_l;
        v_d      = v_q + VOICE_W'(1);
        state_d  = (v_q == LAST_V) ? IDLE : NEXT;
      end
      default: state_d = IDLE;
    endcase

    // A tick mid-sweep abandons the current voice and restarts from voice 0.
    if (tick48k && state_q != IDLE) begin
      overrun_d = 1'b1;
      state_d   = NEXT;
      v_d       = '0;
      wb_we     = 1'b0;
    end

    if (state_d == REQ_R) begin
      r_valid_d = 1'b1;
      r_addr_d  = cur_addr;
    end
    if (state_d == REQ_L) begin
      l_valid_d = 1'b1;
      l_addr_d  = cur_addr;
    end
    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_voice_sweeper.sv
// Scoreboard bench for voice_sweeper: a sweep-level model queues expected
// requests on each tick; a negedge monitor pops and checks every request.
module tb_voice_sweeper;

  localparam int unsigned NV = 4;
  localparam int unsigned PW = 26;

  logic          clk, rst, tick48k, cfg_we, cfg_gate;
  logic [1:0]    cfg_voice;
  logic [PW-1:0] cfg_inc;
  logic [17:0]   cfg_gain_r, cfg_gain_l;
  logic [9:0]    wavetable_r, wavetable_l;
  logic          wavetable_r_valid, wavetable_l_valid, busy, overrun;
  logic [17:0]   volume;

  voice_sweeper #(.NVOICES(NV), .PHASE_W(PW)) dut (
    .clk(clk), .rst(rst), .tick48k(tick48k), .cfg_we(cfg_we),
    .cfg_voice(cfg_voice), .cfg_gate(cfg_gate), .cfg_inc(cfg_inc),
    .cfg_gain_r(cfg_gain_r), .cfg_gain_l(cfg_gain_l),
    .wavetable_r(wavetable_r), .wavetable_r_valid(wavetable_r_valid),
    .wavetable_l(wavetable_l), .wavetable_l_valid(wavetable_l_valid),
    .volume(volume), .busy(busy), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_l;
    logic [9:0]  addr;
    logic [17:0] gain;
  } exp_t;

  exp_t          q[$];
  int            n_checks = 0;
  int            n_pass   = 0;
  bit            mon_en   = 1'b0;

  bit            m_gate  [NV];
  logic [PW-1:0] m_inc   [NV];
  logic [PW-1:0] m_phase [NV];
  logic [17:0]   m_gr    [NV];
  logic [17:0]   m_gl    [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < int'(NV); i++) begin
      m_gate[i] = 1'b0; m_inc[i] = '0; m_phase[i] = '0; m_gr[i] = '0; m_gl[i] = '0;
    end
  endtask

  // Expected requests of one sweep: R then L at the voice's top-10 phase bits,
  // phase advanced once the L request is issued. max_req truncates an aborted sweep.
  task automatic plan_sweep(input int max_req);
    int n = 0;
    for (int v = 0; v < int'(NV); v++) begin
      if (m_gate[v]) begin
        logic [9:0] a = m_phase[v][PW-1 -: 10];
        if (n >= max_req) return;
        q.push_back('{is_l: 1'b0, addr: a, gain: m_gr[v]}); n++;
        if (n >= max_req) return;
        q.push_back('{is_l: 1'b1, addr: a, gain: m_gl[v]}); n++;
        m_phase[v] = m_phase[v] + m_inc[v];
      end
    end
  endtask

  task automatic cfg_write(input int v, input bit g, input logic [PW-1:0] inc,
                           input logic [17:0] gr, input logic [17:0] gl);
    if (!m_gate[v] && g) m_phase[v] = '0;
    m_gate[v] = g; m_inc[v] = inc; m_gr[v] = gr; m_gl[v] = gl;
    cfg_we = 1'b1; cfg_voice = 2'(v); cfg_gate = g; cfg_inc = inc;
    cfg_gain_r = gr; cfg_gain_l = gl;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic pulse_tick();
    tick48k = 1'b1;
    step();
    tick48k = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int i;
    for (i = 0; i < 200; i++) begin
      if (q.size() == 0 && !busy) break;
      step();
    end
    chk({name, "_drain"}, 32'(i < 200), 32'd1);
    repeat (2) step();
  endtask

  task automatic sweep(input string name);
    plan_sweep(1 << 30);
    pulse_tick();
    wait_drain(name);
  endtask

  // Monitor: pops one expectation per request and checks the gain a cycle later.
  initial begin : monitor
    logic [17:0] pend_vol, new_pend;
    bit          zero_next, prev_rv;
    exp_t        e;
    pend_vol = '0; zero_next = 1'b0; prev_rv = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (zero_next) begin
          chk("rst_addr_r",  32'(wavetable_r), 32'd0);
          chk("rst_addr_l",  32'(wavetable_l), 32'd0);
          chk("rst_busy",    32'(busy), 32'd0);
          chk("rst_overrun", 32'(overrun), 32'd0);
        end
        chk("volume", 32'(volume), 32'(pend_vol));
        new_pend = '0;
        if (wavetable_r_valid || wavetable_l_valid) begin
          chk("single_valid", 32'(wavetable_r_valid & wavetable_l_valid), 32'd0);
          chk("req_expected", 32'(q.size() != 0), 32'd1);
          if (q.size() != 0) begin
            e = q.pop_front();
            chk("req_channel", 32'(wavetable_l_valid), 32'(e.is_l));
            chk("req_addr", 32'(e.is_l ? wavetable_l : wavetable_r), 32'(e.addr));
            if (wavetable_l_valid) chk("l_follows_r", 32'(prev_rv), 32'd1);
            new_pend = e.gain;
          end
        end
        prev_rv   = wavetable_r_valid;
        zero_next = rst;
        pend_vol  = rst ? 18'd0 : new_pend;
      end
    end
  end

  initial begin : watchdog
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    rst = 1'b1; tick48k = 1'b0; cfg_we = 1'b0; cfg_voice = '0; cfg_gate = 1'b0;
    cfg_inc = '0; cfg_gain_r = '0; cfg_gain_l = '0;
    clear_model();
    step(); step();
    @(negedge clk);
    chk("reset_addr_r",  32'(wavetable_r), 32'd0);
    chk("reset_valid_r", 32'(wavetable_r_valid), 32'd0);
    chk("reset_addr_l",  32'(wavetable_l), 32'd0);
    chk("reset_valid_l", 32'(wavetable_l_valid), 32'd0);
    chk("reset_volume",  32'(volume), 32'd0);
    chk("reset_busy",    32'(busy), 32'd0);
    chk("reset_overrun", 32'(overrun), 32'd0);
    step();
    rst = 1'b0;
    mon_en = 1'b1;

    // Single voice, then phase stepping by one address per sweep.
    cfg_write(1, 1'b1, PW'(1 << 16), 18'h100, 18'h200);
    plan_sweep(1 << 30);
    pulse_tick();
    chk("busy_in_sweep", 32'(busy), 32'd1);
    wait_drain("single");
    chk("busy_after", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) sweep("step");

    // Note off/on clears phase; near-full increment wraps to 0x3FF.
    cfg_write(1, 1'b0, PW'(1 << 16), 18'h100, 18'h200);
    cfg_write(1, 1'b1, PW'((1 << PW) - (1 << 16)), 18'h111, 18'h222);
    sweep("wrap0");
    sweep("wrap1");

    // All voices active.
    cfg_write(0, 1'b1, PW'(3 << 16), 18'h010, 18'h020);
    cfg_write(2, 1'b1, PW'(5 << 16), 18'h030, 18'h040);
    cfg_write(3, 1'b1, PW'(7 << 16), 18'h050, 18'h060);
    sweep("all");

    // Tick during REQ_R of voice 2 (8 cycles after the first tick).
    plan_sweep(5);
    pulse_tick();
    repeat (7) step();
    chk("overrun_before", 32'(overrun), 32'd0);
    plan_sweep(1 << 30);
    pulse_tick();
    chk("overrun_set", 32'(overrun), 32'd1);
    wait_drain("abort");
    chk("overrun_sticky", 32'(overrun), 32'd1);

    // Config write on voice 1 during its REQ_L: old values now, new next sweep.
    cfg_write(0, 1'b0, '0, '0, '0);
    cfg_write(2, 1'b0, '0, '0, '0);
    cfg_write(3, 1'b0, '0, '0, '0);
    plan_sweep(1 << 30);
    pulse_tick();
    repeat (3) step();
    cfg_write(1, 1'b1, PW'(9 << 16), 18'h3ABCD, 18'h01234);
    wait_drain("midwrite");
    sweep("midwrite_next");

    // Randomized configurations, written while idle.
    for (int it = 0; it < 8; it++) begin
      int nw = int'($urandom_range(1, 4));
      for (int w = 0; w < nw; w++)
        cfg_write(int'($urandom_range(0, NV - 1)), bit'($urandom_range(0, 3) != 0),
                  PW'($urandom), 18'($urandom), 18'($urandom));
      sweep("random");
      repeat (int'($urandom_range(0, 3))) step();
    end

    // Reset mid-sweep clears outputs, state and table.
    for (int v = 0; v < int'(NV); v++) cfg_write(v, 1'b1, PW'(1 << 20), 18'h5, 18'h6);
    plan_sweep(1 << 30);
    pulse_tick();
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    q.delete();
    clear_model();
    chk("rst_mid_busy", 32'(busy), 32'd0);
    sweep("empty_table");
    cfg_write(2, 1'b1, PW'(1 << 16), 18'h77, 18'h88);
    sweep("after_reset");
    chk("final_queue_empty", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
